// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: sync, visible-area flag and pixel coordinates, registered one clock behind hc/vc.
// Optional macro VGA_FRAME_COUNT_EN adds an 8-bit frame_count output.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    // Thresholds are 11 bits so a sync window ending at exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic        SYNC_ACT   = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic        SYNC_IDLE  = (SYNC_POL != 0) ? 1'b0 : 1'b1;

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic [9:0]  draw_x_q, draw_x_d;
    logic [9:0]  draw_y_q, draw_y_d;
    logic        frame_start_q, frame_start_d;
    logic [10:0] hc_x_s, vc_x_s;

    // Raster counters: hc wraps every line, vc steps on the hc wrap and wraps with it at frame end.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            if (vc_q == V_LAST) begin
                vc_d = 10'd0;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end else begin
            hc_d = hc_q + 10'd1;
        end
    end

    // Output decode of the current counter position; captured on the next edge.
    always_comb begin
        hc_x_s        = {1'b0, hc_q};
        vc_x_s        = {1'b0, vc_q};
        draw_x_d      = hc_q;
        draw_y_d      = vc_q;
        blank_d       = (hc_x_s < H_VIS_END) && (vc_x_s < V_VIS_END);
        frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0);
        if ((hc_x_s >= H_SYNC_BEG) && (hc_x_s < H_SYNC_END)) begin
            hs_d = SYNC_ACT;
        end else begin
            hs_d = SYNC_IDLE;
        end
        if ((vc_x_s >= V_SYNC_BEG) && (vc_x_s < V_SYNC_END)) begin
            vs_d = SYNC_ACT;
        end else begin
            vs_d = SYNC_IDLE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            hs_q          <= SYNC_IDLE;
            vs_q          <= SYNC_IDLE;
            blank_q       <= 1'b0;
            draw_x_q      <= 10'd0;
            draw_y_q      <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count_q, frame_count_d;
    logic       fc_seen_q, fc_seen_d;

    // First frame after reset reads 0; each later frame start advances the count.
    always_comb begin
        frame_count_d = frame_count_q;
        fc_seen_d     = fc_seen_q;
        if (frame_start_d) begin
            fc_seen_d = 1'b1;
            if (fc_seen_q) begin
                frame_count_d = frame_count_q + 8'd1;
            end else begin
                frame_count_d = frame_count_q;
            end
        end else begin
            fc_seen_d = fc_seen_q;
        end
    end

    // Frame counter registers.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            frame_count_q <= 8'd0;
            fc_seen_q     <= 1'b0;
        end else begin
            frame_count_q <= frame_count_d;
            fc_seen_q     <= fc_seen_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule
